// File: rtl/log_tap_mac_if.sv
// Term/result bus for log_tap_mac: one log-domain product term in per cycle,
// one saturated frame sum out per frame. No back-pressure.
interface log_tap_mac_if #(
  parameter int WIDTH     = 16,
  parameter int LOG_WIDTH = 17
);
  logic                 in_valid;
  logic                 in_first;
  logic                 in_last;
  logic [LOG_WIDTH-1:0] log_weight;
  logic                 log_weight_sign;
  logic                 log_weight_valid;
  logic [LOG_WIDTH-1:0] log_x;
  logic                 log_x_sign;
  logic                 log_x_valid;
  logic [WIDTH-1:0]     y_out;
  logic                 y_valid;
  logic                 frame_err;

  modport master (
    output in_valid, in_first, in_last,
    output log_weight, log_weight_sign, log_weight_valid,
    output log_x, log_x_sign, log_x_valid,
    input  y_out, y_valid, frame_err
  );

  modport slave (
    input  in_valid, in_first, in_last,
    input  log_weight, log_weight_sign, log_weight_valid,
    input  log_x, log_x_sign, log_x_valid,
    output y_out, y_valid, frame_err
  );
endinterface

// File: rtl/log_tap_mac.sv
// Log-domain multiply-accumulate for the log-TFLAF tap chain.
// Products are formed by adding log2 magnitudes and taking a Mitchell
// antilog, then summed over a frame and saturated to WIDTH bits.
// Optional build macro LOG_TAP_MAC_ROUND_EN: antilog right shifts round
// half-up instead of truncating.
module log_tap_mac #(
  parameter int WIDTH     = 16,
  parameter int QP        = 12,
  parameter int LOG_WIDTH = 17,
  parameter int MAX_TAPS  = 32,
  parameter int GUARD     = 5
) (
  input logic           clk,
  input logic           reset,
  log_tap_mac_if.slave  bus
);

  localparam int ACC_W  = WIDTH + GUARD;
  localparam int LSUM_W = LOG_WIDTH + 1;
  localparam int IW     = LSUM_W - 12;
  localparam int SH_OFF = QP - 12;
  localparam int CNT_W  = $clog2(MAX_TAPS + 2);

  localparam logic [63:0]             MAX_MAG64 = (64'd1 << (ACC_W - 1)) - 64'd1;
  localparam logic signed [ACC_W-1:0] SAT_HI    = ACC_W'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO    = ~SAT_HI;

  typedef enum logic {IDLE, ACC} state_t;

  logic              s1_valid, s1_first, s1_last, s1_psign, s1_pzero;
  logic [LSUM_W-1:0] s1_lsum;

  logic                    s2_valid, s2_first, s2_last;
  logic signed [ACC_W-1:0] s2_term;

  logic signed [IW-1:0]    int_part;
  logic signed [IW:0]      sh;
  logic signed [IW:0]      neg_sh;
  logic [12:0]             mant;
  logic [63:0]             mant_wide;
  logic [63:0]             shifted;
  logic [ACC_W-1:0]        mag;
  logic signed [ACC_W-1:0] term;
`ifdef LOG_TAP_MAC_ROUND_EN
  logic [63:0]             ext_r;
`endif

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        tap_count;
  logic                    emit;
  logic [WIDTH-1:0]        y_sat;

  // S1: log-domain multiply (add exponents) and product sign/zero flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_psign <= 1'b0;
      s1_pzero <= 1'b1;
      s1_lsum  <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      s1_first <= bus.in_first;
      s1_last  <= bus.in_last;
      s1_psign <= bus.log_weight_sign ^ bus.log_x_sign;
      s1_pzero <= ~(bus.log_weight_valid & bus.log_x_valid);
      s1_lsum  <= {bus.log_weight[LOG_WIDTH-1], bus.log_weight}
                + {bus.log_x[LOG_WIDTH-1], bus.log_x};
    end
  end

  // S2 datapath: Mitchell antilog by shifting 1.frac, clamp, then apply sign
  always_comb begin
    int_part  = s1_lsum[LSUM_W-1:12];
    mant      = {1'b1, s1_lsum[11:0]};
    mant_wide = 64'(mant);
    sh        = {int_part[IW-1], int_part} + (IW + 1)'(SH_OFF);
    neg_sh    = -sh;
    shifted   = '0;
`ifdef LOG_TAP_MAC_ROUND_EN
    ext_r     = '0;
`endif
    if (sh >= 0) begin
      shifted = mant_wide << sh;
    end else begin
`ifdef LOG_TAP_MAC_ROUND_EN
      ext_r   = {mant_wide[62:0], 1'b0} >> neg_sh;
      shifted = {1'b0, ext_r[63:1]} + {63'd0, ext_r[0]};
`else
      shifted = mant_wide >> neg_sh;
`endif
    end
    if (shifted > MAX_MAG64) begin
      mag = MAX_MAG64[ACC_W-1:0];
    end else begin
      mag = shifted[ACC_W-1:0];
    end
    if (s1_pzero) begin
      term = '0;
    end else if (s1_psign) begin
      term = ACC_W'(0) - mag;
    end else begin
      term = mag;
    end
  end

  // S2 register: linear product term plus framing flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_term  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_term  <= term;
    end
  end

  // S3: framing FSM, accumulator and tap counter; stray or overlong terms flag frame_err
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      acc           <= '0;
      tap_count     <= '0;
      emit          <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      emit          <= 1'b0;
      bus.frame_err <= 1'b0;
      if (s2_valid) begin
        case (state)
          IDLE: begin
            if (s2_first) begin
              acc       <= s2_term;
              tap_count <= CNT_W'(1);
              if (s2_last) begin
                emit <= 1'b1;
              end else begin
                state <= ACC;
              end
            end else begin
              bus.frame_err <= 1'b1;
            end
          end
          ACC: begin
            if (s2_first) begin
              acc           <= s2_term;
              tap_count     <= CNT_W'(1);
              bus.frame_err <= 1'b1;
            end else begin
              acc <= acc + s2_term;
              if (tap_count <= CNT_W'(MAX_TAPS)) begin
                tap_count <= tap_count + CNT_W'(1);
              end
              if (tap_count == CNT_W'(MAX_TAPS)) begin
                bus.frame_err <= 1'b1;
              end
            end
            if (s2_last) begin
              emit  <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Saturate the wide accumulator to the WIDTH-bit output range
  always_comb begin
    if (acc > SAT_HI) begin
      y_sat = SAT_HI[WIDTH-1:0];
    end else if (acc < SAT_LO) begin
      y_sat = SAT_LO[WIDTH-1:0];
    end else begin
      y_sat = acc[WIDTH-1:0];
    end
  end

  // Output register: load the saturated sum once per completed frame, hold otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.y_out   <= '0;
      bus.y_valid <= 1'b0;
    end else begin
      bus.y_valid <= emit;
      if (emit) begin
        bus.y_out <= y_sat;
      end
    end
  end

endmodule

// File: doc/log_tap_mac.md
# log_tap_mac

Log-domain multiply-accumulate stage that sits directly downstream of the LMS weight-update taps in the log-TFLAF datapath. It consumes one (log weight, log expanded-input) pair per cycle, multiplies each pair by log addition and Mitchell antilog, and accumulates the products over a frame of taps. At frame end it emits the saturated linear filter output y(n).

## Interface
- WIDTH, 16: linear data width, two's complement, QP fractional bits.
- QP, 12: fractional bits of the linear format.
- LOG_WIDTH, 17: log word width, signed Q5.12.
- MAX_TAPS, 32: maximum terms per frame.
- GUARD, 5: accumulator guard bits; accumulator width is WIDTH+GUARD.

Ports:
- clk  in  1  clock; all flops on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  the term on the inputs is valid this cycle.
- in_first  in  1  with in_valid: first term of a frame.
- in_last  in  1  with in_valid: last term of a frame; may coincide with in_first.
- log_weight  in  LOG_WIDTH  log2 magnitude of the weight, Q5.12.
- log_weight_sign  in  1  weight sign, 1 = negative.
- log_weight_valid  in  1  0 = weight is zero; the term contributes 0.
- log_x  in  LOG_WIDTH  log2 magnitude of the expanded input, Q5.12.
- log_x_sign  in  1  input sign.
- log_x_valid  in  1  0 = input is zero.
- y_out  out  WIDTH  saturated frame sum, Q(WIDTH-QP).QP.
- y_valid  out  1  one-cycle pulse; y_out holds the new sum.
- frame_err  out  1  one-cycle pulse on a framing violation.

## Operation
- No back-pressure. in_valid qualifies every input, and a term is accepted every cycle in_valid=1.
- S1 register:
  - lsum = log_weight + log_x, sign-extended to LOG_WIDTH+1.
  - psign = log_weight_sign ^ log_x_sign.
  - pzero = ~(log_weight_valid & log_x_valid).
  - first/last flags.
- S2 antilog:
  - mant = {1, lsum[11:0]}, 13 bits.
  - sh = lsum integer part + QP − 12.
  - sh ≥ 0: mant << sh. sh < 0: mant >> −sh.
  - If the shifted magnitude exceeds 2^(WIDTH+GUARD−1)−1, clamp it to that value.
  - If pzero, the result is 0.
  - Negate when psign=1. Register term plus flags.
- S3 accumulate: acc is WIDTH+GUARD bits and wraps on overflow (guard bits make wrap a misuse).
  - First term: acc <= term.
  - Other terms: acc <= acc + term.
- FSM states and transitions (state advances on S3 terms):
  - IDLE, S3 term with first: enter ACC.
  - IDLE, S3 term with first and last: stay IDLE, emit output.
  - IDLE, S3 term without first: drop the term, pulse frame_err.
  - ACC, term without first: accumulate.
  - ACC, term with first: restart the sum with this term, pulse frame_err.
  - ACC, term with last: go to IDLE, emit output.
- Tap counter: counts terms in the current frame.
  - The term that brings the count above MAX_TAPS is still accumulated and pulses frame_err.
  - Cleared on first.
- Output: y_out is acc saturated to WIDTH bits, ±(2^(WIDTH−1)−1 / −2^(WIDTH−1)), registered.

## Timing
- Reset values: y_out=0, y_valid=0, frame_err=0, acc=0, FSM=IDLE, tap counter=0, all pipeline valids=0.
- Latency: a term presented with in_last at cycle t gives y_valid=1 at t+4.
  - S1 at t+1, S2 at t+2, S3 at t+3, output register at t+4.
- Throughput: one term per cycle. Back-to-back frames are allowed, with in_first in the cycle after in_last.
- y_out holds its value between y_valid pulses.
- frame_err is aligned with the S3 cycle of the offending term, i.e. t+3.
- Reset asserted mid-frame:
  - Everything clears asynchronously and the partial sum is lost.
  - No y_valid is produced for that frame.

## Configuration
- LOG_TAP_MAC_ROUND_EN defined: right shifts in S2 round half-up by adding the last shifted-out bit.
- Not defined: right shifts truncate.
- Left shifts are identical in both builds.

## Test plan
- Frame of 2 terms:
  - Term 1: log_weight=17'h1F000 (+0.5), log_x=17'h1F000 (+0.5).
  - Term 2: log_weight=17'h1F000 (−0.5, sign=1), log_x=17'h1E000 (+0.25).
  - Expected: y_out=16'h0200 (0.125), y_valid 4 cycles after last.
- Single term, first=last=1, log_weight_valid=0, log_x=0: y_out=0, frame_err=0.
- Frame of 4 terms, each log_weight=17'h03000 (8.0), log_x=17'h03000 (8.0): y_out=16'h7FFF. Same frame with both signs negative on one operand: y_out=16'h8000.
- in_valid with in_first=0 in IDLE: frame_err pulses, no y_valid; a following valid frame sums correctly.
- MAX_TAPS+1 terms of 0.5×0.5: frame_err on term 33; y_out=16'h7FFF (33×1024 saturates).
- Reset pulsed low after 2 terms of a 4-term frame:
  - Outputs read 0 immediately and no y_valid follows.
  - Next frame {0.5×0.5} gives y_out=16'h0400.
- Term with lsum = 17'h1A800 (2^−5.5 ≈ 1.5×2^−6): check y_out against the S2 right-shift rule in both builds. 16'h0060 is the exact result; the low bit differs between truncate and round only when the shifted-out bit is 1.
